// File: rtl/wallace_mult_pipe.sv
// Pipelined WIDTH x WIDTH Wallace-tree multiplier. Each transaction selects unsigned or
// two's-complement operation and carries a sideband tag. The product is exact in 2*WIDTH bits.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module wallace_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int PW    = 2 * WIDTH;
  localparam int NROWS = WIDTH + 1;

  // Row count left after 'lvls' layers of 3:2 compression.
  function automatic int rows_after(input int n, input int lvls);
    int m;
    m = n;
    for (int k = 0; k < lvls; k++) m = 2 * (m / 3) + (m % 3);
    return m;
  endfunction

  function automatic int num_levels(input int n);
    int m;
    int l;
    m = n;
    l = 0;
    while (m > 2) begin
      m = 2 * (m / 3) + (m % 3);
      l++;
    end
    return l;
  endfunction

  localparam int NLEV = num_levels(NROWS);

  // Handshake: a word moves on any rising edge where valid & ready are both high.
  // The pipe freezes as a whole while the output is held (stall); in_ready is the
  // complement of stall and never looks at in_valid.
  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Modified Baugh-Wooley matrix: in signed mode, products that mix exactly one
  // sign bit are inverted, and constant ones enter at columns WIDTH and 2*WIDTH-1.
  logic [PW-1:0] pp [NROWS];

  always_comb begin
    for (int r = 0; r < NROWS; r++) pp[r] = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp[i][i+j] = (in_a[j] & in_b[i]) ^
                     (in_signed & ((i == WIDTH - 1) ^ (j == WIDTH - 1)));
      end
    end
    pp[WIDTH][WIDTH]  = in_signed;
    pp[WIDTH][PW-1]   = in_signed;
  end

  // Stage 1: partial-product matrix
  logic             s1_valid;
  logic [PW-1:0]    s1_pp [NROWS];
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !stall && in_valid) begin
      s1_pp  <= pp;
      s1_tag <= in_tag;
    end
  end

  // Wallace reduction: rows grouped in threes per layer, each group becoming a
  // sum row and a carry row; leftover rows pass straight through.
  logic [PW-1:0] lvl [NLEV+1][NROWS];

  for (genvar r = 0; r < NROWS; r++) begin : g_lvl0
    assign lvl[0][r] = s1_pp[r];
  end

  for (genvar l = 0; l < NLEV; l++) begin : g_lvl
    localparam int N  = rows_after(NROWS, l);
    localparam int G  = N / 3;
    localparam int NN = 2 * G + (N % 3);

    for (genvar g = 0; g < G; g++) begin : g_csa
      logic [PW-1:0] s;
      logic [PW-1:0] c;
      for (genvar b = 0; b < PW - 1; b++) begin : g_fa
        full_adder u_fa (
          .a    (lvl[l][3*g][b]),
          .b    (lvl[l][3*g+1][b]),
          .cin  (lvl[l][3*g+2][b]),
          .sum  (s[b]),
          .cout (c[b+1])
        );
      end
      // The carry out of the top column falls outside the product and is not formed.
      assign s[PW-1] = lvl[l][3*g][PW-1] ^ lvl[l][3*g+1][PW-1] ^ lvl[l][3*g+2][PW-1];
      assign c[0]    = 1'b0;
      assign lvl[l+1][2*g]   = s;
      assign lvl[l+1][2*g+1] = c;
    end

    for (genvar r = 2 * G; r < NROWS; r++) begin : g_pass
      if (r < NN) begin : g_keep
        assign lvl[l+1][r] = lvl[l][r+G];
      end else begin : g_zero
        assign lvl[l+1][r] = '0;
      end
    end
  end

  // Stage 2: two-row carry-save result
  logic             s2_valid;
  logic [PW-1:0]    s2_sum;
  logic [PW-1:0]    s2_carry;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !stall && s1_valid) begin
      s2_sum   <= lvl[NLEV][0];
      s2_carry <= lvl[NLEV][1];
      s2_tag   <= s1_tag;
    end
  end

  // Stage 3: carry-propagate add; the product only changes when a valid word lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_tag   <= '0;
    end else if (!stall) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_prod <= s2_sum + s2_carry;
        out_tag  <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Bench for wallace_mult_pipe: directed corner cases, stall and reset behaviour, and
// randomized traffic at WIDTH=8 and WIDTH=16 checked by an expected-value queue.

module tb_wallace_mult_pipe;
  localparam int W  = 8;
  localparam int TW = 4;
  localparam int WW = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // WIDTH=8 instance
  logic            rst, in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [W-1:0]    in_a, in_b;
  logic [TW-1:0]   in_tag, out_tag;
  logic [2*W-1:0]  out_prod;

  wallace_mult_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod), .out_tag(out_tag)
  );

  // WIDTH=16 instance
  logic            rst_w, iv_w, ir_w, is_w, ov_w, or_w;
  logic [WW-1:0]   a_w, b_w;
  logic [TW-1:0]   it_w, ot_w;
  logic [2*WW-1:0] op_w;

  wallace_mult_pipe #(.WIDTH(WW), .TAG_W(TW)) dut_w (
    .clk(clk), .rst(rst_w), .in_valid(iv_w), .in_ready(ir_w),
    .in_a(a_w), .in_b(b_w), .in_signed(is_w), .in_tag(it_w),
    .out_valid(ov_w), .out_ready(or_w), .out_prod(op_w), .out_tag(ot_w)
  );

  int total = 0;
  int bad   = 0;

  logic [TW+2*W-1:0]  exp_q[$];
  logic [TW+2*WW-1:0] expw_q[$];

  int             n_out = 0;
  logic [2*W-1:0] last_prod;
  logic           bp_en = 1'b0;
  logic           done_w = 1'b0;

  // reference model: plain integer multiplication
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input int w, input logic s);
    longint x, y;
    x = longint'(a);
    y = longint'(b);
    if (s && a[w-1]) x = x - (longint'(1) << w);
    if (s && b[w-1]) y = y - (longint'(1) << w);
    return 64'(x * y);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic [TW-1:0] t);
    int n;
    logic acc;
    logic [63:0] p;
    n = 0;
    acc = 1'b0;
    p = ref_prod(32'(a), 32'(b), W, s);
    in_a = a; in_b = b; in_signed = s; in_tag = t; in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      if (acc) exp_q.push_back({t, p[2*W-1:0]});
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
    end
    in_valid = 1'b0;
  endtask

  task automatic send_w(input logic [WW-1:0] a, input logic [WW-1:0] b,
                        input logic s, input logic [TW-1:0] t);
    int n;
    logic acc;
    logic [63:0] p;
    n = 0;
    acc = 1'b0;
    p = ref_prod(32'(a), 32'(b), WW, s);
    a_w = a; b_w = b; is_w = s; it_w = t; iv_w = 1'b1;
    do begin
      @(negedge clk);
      acc = ir_w;
      if (acc) expw_q.push_back({t, p[2*WW-1:0]});
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_w_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
    end
    iv_w = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // random backpressure
  always @(posedge clk) begin
    #1;
    if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
    or_w = ($urandom_range(0, 3) != 0);
  end

  // scoreboard monitors
  logic [TW+2*W-1:0]  e8;
  logic [TW+2*WW-1:0] ew;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out: got prod %0h tag %0h, expected no result", out_prod, out_tag);
      end else begin
        e8 = exp_q.pop_front();
        check("prod8", 64'(out_prod), 64'(e8[2*W-1:0]));
        check("tag8", 64'(out_tag), 64'(e8[TW+2*W-1:2*W]));
      end
      last_prod = out_prod;
      n_out++;
    end
  end

  always @(negedge clk) begin
    if (!rst_w && ov_w && or_w) begin
      if (expw_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out_w: got prod %0h, expected no result", op_w);
      end else begin
        ew = expw_q.pop_front();
        check("prod16", 64'(op_w), 64'(ew[2*WW-1:0]));
        check("tag16", 64'(ot_w), 64'(ew[TW+2*WW-1:2*WW]));
      end
    end
  end

  // WIDTH=16 random traffic
  initial begin
    rst_w = 1'b1; iv_w = 1'b0; a_w = '0; b_w = '0; is_w = 1'b0; it_w = '0;
    idle(3);
    rst_w = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      send_w(WW'($urandom), WW'($urandom), 1'($urandom_range(0, 1)), TW'(i));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    done_w = 1'b1;
  end

  // main sequence
  initial begin
    logic [W-1:0] lst_a [8];
    logic [63:0]  pa;
    int c0, n0, guard;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0;
    out_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_prod", 64'(out_prod), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // latency and largest unsigned product
    send(8'hFF, 8'hFF, 1'b0, 4'd3);
    check("lat_c1", 64'(out_valid), 64'd0);
    idle(1);
    check("lat_c2", 64'(out_valid), 64'd0);
    idle(1);
    check("lat_c3", 64'(out_valid), 64'd1);
    check("lat_prod", 64'(out_prod), 64'hFE01);
    check("lat_tag", 64'(out_tag), 64'd3);
    idle(2);

    // signed corners
    send(8'h80, 8'h80, 1'b1, 4'd1); idle(4);
    check("neg128_sq", 64'(last_prod), 64'h4000);
    send(8'hFF, 8'h01, 1'b1, 4'd2); idle(4);
    check("neg1_x_1", 64'(last_prod), 64'hFFFF);
    send(8'h7F, 8'h80, 1'b1, 4'd3); idle(4);
    check("p127_x_n128", 64'(last_prod), 64'hC080);

    // back-to-back mixed stream
    n0 = n_out;
    c0 = cyc;
    for (int i = 0; i < 100; i++)
      send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), TW'(i % 16));
    check("stream_issue_cycles", 64'(cyc - c0), 64'd100);
    idle(5);
    check("stream_count", 64'(n_out - n0), 64'd100);

    // stall: fill three, hold, release
    out_ready = 1'b0;
    pa = ref_prod(32'd200, 32'd100, W, 1'b0);
    send(8'd200, 8'd100, 1'b0, 4'd5);
    send(8'hF3, 8'd77, 1'b1, 4'd6);
    send(8'd19, 8'hC1, 1'b1, 4'd7);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_prod", 64'(out_prod), 64'(pa[2*W-1:0]));
      check("stall_tag", 64'(out_tag), 64'd5);
      @(posedge clk); #1;
    end
    n0 = n_out;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("drain_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("drain_empty", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check("drain_count", 64'(n_out - n0), 64'd3);

    // reset with two in flight
    send(8'd12, 8'd13, 1'b0, 4'd7);
    send(8'd14, 8'hF1, 1'b1, 4'd8);
    rst = 1'b1;
    exp_q.delete();
    idle(1);
    rst = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_prod", 64'(out_prod), 64'd0);
    check("flush_out_tag", 64'(out_tag), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    idle(8);

    // operand sweep under random backpressure
    lst_a[0] = 8'h00; lst_a[1] = 8'h01; lst_a[2] = 8'h02; lst_a[3] = 8'h7F;
    lst_a[4] = 8'h80; lst_a[5] = 8'h81; lst_a[6] = 8'hFE; lst_a[7] = 8'hFF;
    bp_en = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int j = 0; j < 10; j++) begin
        for (int s = 0; s < 2; s++) begin
          if (j < 8) send(W'(a), lst_a[j], 1'(s), TW'(j));
          else       send(W'(a), W'($urandom), 1'(s), TW'(a));
        end
      end
    end
    bp_en = 1'b0;
    out_ready = 1'b1;

    guard = 0;
    while ((!done_w || exp_q.size() != 0 || expw_q.size() != 0) && guard < 40000) begin
      idle(1);
      guard++;
    end
    idle(6);
    check("final_q8_empty", 64'(exp_q.size()), 64'd0);
    check("final_q16_empty", 64'(expw_q.size()), 64'd0);
    check("w16_done", 64'(done_w), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
